mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//    Data-memory access sequencer between a simple 8-bit CPU and a data memory
//    that stalls through MEM_BUSYWAIT. One access at a time: a load or store
//    decoded in IDLE is latched, the memory command is held until the memory
//    drops MEM_BUSYWAIT, and a load then gets one register-file write-back
//    cycle. The CPU is stalled through BUSYWAIT for the whole access except
//    the write-back cycle.
//
//    Optional build macro: MEM_ACCESS_CTRL_TIMEOUT_EN
//       defined   : an 8-bit wait counter aborts an access after
//                   TIMEOUT_CYCLES busy cycles and sets the sticky TIMEOUT.
//       undefined : the controller waits on the memory indefinitely and
//                   TIMEOUT is tied low.
//
//    Parameter
//       TIMEOUT_CYCLES  1..255, busy cycles allowed before an abort
//
//    Ports
//       CLK, RESET                    clock, synchronous active-high reset
//       READ_REQ, WRITE_REQ           decoded load / store this cycle
//       ADDRESS, WDATA, DEST_REG      access address, store data, load target
//       MEM_READDATA, MEM_BUSYWAIT    memory response
//       MEM_READ, MEM_WRITE           memory command strobes
//       MEM_ADDRESS, MEM_WRITEDATA    latched address and store data
//       BUSYWAIT                      CPU stall
//       RF_WRITE, RF_INADDRESS, RF_IN load write-back to the register file
//       TIMEOUT                       sticky access-abort flag
//
//    state   | meaning
//    --------+---------------------------------------------------------
//    IDLE    | no access; accept a load (priority) or a store
//    RD_WAIT | MEM_READ held until the memory is no longer busy
//    WR_WAIT | MEM_WRITE held until the memory is no longer busy
//    WB      | one-cycle register-file write of the loaded byte

module mem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       READ_REQ,
   input  logic       WRITE_REQ,
   input  logic [7:0] ADDRESS,
   input  logic [7:0] WDATA,
   input  logic [2:0] DEST_REG,
   input  logic [7:0] MEM_READDATA,
   input  logic       MEM_BUSYWAIT,
   output logic       MEM_READ,
   output logic       MEM_WRITE,
   output logic [7:0] MEM_ADDRESS,
   output logic [7:0] MEM_WRITEDATA,
   output logic       BUSYWAIT,
   output logic       RF_WRITE,
   output logic [2:0] RF_INADDRESS,
   output logic [7:0] RF_IN,
   output logic       TIMEOUT
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      WB      = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [2:0] dest_q, dest_d;
   logic [7:0] rdbuf_q, rdbuf_d;
   logic [2:0] rf_addr_q, rf_addr_d;

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       timeout_q, timeout_d;
   logic [7:0] wait_cnt_inc;
   logic       wait_expired;

   // The busy cycle that brings the count to the limit is the last one
   // allowed, so TIMEOUT_CYCLES busy cycles are spent in the wait state.
   assign wait_cnt_inc = wait_cnt_q + 8'd1;
   assign wait_expired = (wait_cnt_inc == TIMEOUT_LIMIT);
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         addr_q     <= 8'h00;
         wdata_q    <= 8'h00;
         dest_q     <= 3'd0;
         rdbuf_q    <= 8'h00;
         rf_addr_q  <= 3'd0;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
         wait_cnt_q <= 8'h00;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         dest_q     <= dest_d;
         rdbuf_q    <= rdbuf_d;
         rf_addr_q  <= rf_addr_d;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      dest_d     = dest_q;
      rdbuf_d    = rdbuf_q;
      rf_addr_d  = rf_addr_q;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (READ_REQ) begin
               addr_d  = ADDRESS;
               dest_d  = DEST_REG;
               state_d = RD_WAIT;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
               wait_cnt_d = 8'h00;
`endif
            end else if (WRITE_REQ) begin
               addr_d  = ADDRESS;
               wdata_d = WDATA;
               state_d = WR_WAIT;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
               wait_cnt_d = 8'h00;
`endif
            end
         end

         RD_WAIT: begin
            if (!MEM_BUSYWAIT) begin
               // The write-back index is copied here rather than driven from
               // dest_q so it stays stable while the next load is latched.
               rdbuf_d   = MEM_READDATA;
               rf_addr_d = dest_q;
               state_d   = WB;
            end else begin
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
               wait_cnt_d = wait_cnt_inc;
               if (wait_expired) begin
                  timeout_d = 1'b1;
                  state_d   = IDLE;
               end
`endif
            end
         end

         WR_WAIT: begin
            if (!MEM_BUSYWAIT) begin
               state_d = IDLE;
            end else begin
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
               wait_cnt_d = wait_cnt_inc;
               if (wait_expired) begin
                  timeout_d = 1'b1;
                  state_d   = IDLE;
               end
`endif
            end
         end

         WB: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      MEM_READ      = (state_q == RD_WAIT);
      MEM_WRITE     = (state_q == WR_WAIT);
      MEM_ADDRESS   = addr_q;
      MEM_WRITEDATA = wdata_q;
      RF_WRITE      = (state_q == WB);
      RF_INADDRESS  = rf_addr_q;
      RF_IN         = rdbuf_q;
      // Gated by RESET so the CPU is never stalled while the controller is
      // being forced back to IDLE.
      BUSYWAIT      = !RESET &&
                      ((state_q == RD_WAIT) || (state_q == WR_WAIT) ||
                       ((state_q == IDLE) && (READ_REQ || WRITE_REQ)));
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
      TIMEOUT       = timeout_q;
`else
      TIMEOUT       = 1'b0;
`endif
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       read_req = 1'b0;
   logic       write_req = 1'b0;
   logic [7:0] address = 8'h00;
   logic [7:0] wdata = 8'h00;
   logic [2:0] dest_reg = 3'd0;
   logic [7:0] mem_readdata;
   logic       mem_busywait;
   logic       mem_read, mem_write;
   logic [7:0] mem_address, mem_writedata;
   logic       busywait, rf_write, timeout;
   logic [2:0] rf_inaddress;
   logic [7:0] rf_in;

   int checks = 0;
   int errors = 0;

   // Memory model: busy for mem_wait_cfg cycles of each access, read data
   // valid only once it is no longer busy.
   int         mem_wait_cfg = 0;
   logic [7:0] rdata_cfg = 8'h00;
   int         acc_cyc = 0;

   typedef struct {
      bit         wr;
      logic [7:0] addr;
      logic [7:0] data;
      int         len;
   } cmd_t;

   typedef struct {
      logic [2:0] idx;
      logic [7:0] data;
   } wb_t;

   cmd_t cmd_q[$];
   wb_t  wb_q[$];

   logic [2:0] last_idx = 3'd0;
   logic [7:0] last_data = 8'h00;

   mem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .CLK          (clk),
      .RESET        (rst),
      .READ_REQ     (read_req),
      .WRITE_REQ    (write_req),
      .ADDRESS      (address),
      .WDATA        (wdata),
      .DEST_REG     (dest_reg),
      .MEM_READDATA (mem_readdata),
      .MEM_BUSYWAIT (mem_busywait),
      .MEM_READ     (mem_read),
      .MEM_WRITE    (mem_write),
      .MEM_ADDRESS  (mem_address),
      .MEM_WRITEDATA(mem_writedata),
      .BUSYWAIT     (busywait),
      .RF_WRITE     (rf_write),
      .RF_INADDRESS (rf_inaddress),
      .RF_IN        (rf_in),
      .TIMEOUT      (timeout)
   );

   always #5 clk = ~clk;

   assign mem_busywait = (mem_read || mem_write) && (acc_cyc < mem_wait_cfg);
   assign mem_readdata = mem_busywait ? 8'hEE : rdata_cfg;

   always @(posedge clk) acc_cyc <= (mem_read || mem_write) ? acc_cyc + 1 : 0;

   task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected DUT output (t=%0t)", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops expectations whenever a memory command or write-back shows up.
   bit   act = 1'b0;
   bit   have_exp = 1'b0;
   int   act_len = 0;
   cmd_t cur;

   always @(negedge clk) begin
      if (mem_read || mem_write) begin
         if (!act) begin
            if (cmd_q.size() == 0) begin
               fail_now("cmd_unexpected");
               have_exp = 1'b0;
            end else begin
               cur = cmd_q.pop_front();
               have_exp = 1'b1;
               chk("cmd_read", mem_read, !cur.wr);
               chk("cmd_write", mem_write, cur.wr);
            end
            act = 1'b1;
            act_len = 0;
         end
         act_len++;
         if (have_exp) begin
            chk("cmd_addr", mem_address, cur.addr);
            if (cur.wr) chk("cmd_wdata", mem_writedata, cur.data);
         end
      end else if (act) begin
         act = 1'b0;
         if (have_exp) chk("cmd_len", act_len, cur.len);
      end

      if (rf_write) begin
         if (wb_q.size() == 0) begin
            fail_now("rf_write_unexpected");
         end else begin
            wb_t e;
            e = wb_q.pop_front();
            chk("wb_idx", rf_inaddress, e.idx);
            chk("wb_data", rf_in, e.data);
         end
      end
   end

   task automatic do_load(input logic [7:0] a, input logic [2:0] d, input logic [7:0] rd,
                          input int w, input bit also_wr, input bit noise);
      mem_wait_cfg = w;
      rdata_cfg = rd;
      cmd_q.push_back(cmd_t'{1'b0, a, 8'h00, w + 1});
      wb_q.push_back(wb_t'{d, rd});
      read_req = 1'b1;
      write_req = also_wr;
      address = a;
      dest_reg = d;
      wdata = ~a;
      #1 chk("busy_ld_req", busywait, 1);
      tick();
      read_req = 1'b0;
      write_req = noise;
      address = ~a;
      dest_reg = ~d;
      wdata = 8'h55;
      #1;
      chk("rf_idx_hold", rf_inaddress, last_idx);
      chk("rf_data_hold", rf_in, last_data);
      for (int i = 0; i <= w; i++) begin
         chk("busy_rd_wait", busywait, 1);
         tick();
      end
      chk("busy_wb", busywait, 0);
      chk("rf_write_wb", rf_write, 1);
      write_req = 1'b0;
      last_idx = d;
      last_data = rd;
      tick();
   endtask

   task automatic do_store(input logic [7:0] a, input logic [7:0] dt, input int w);
      mem_wait_cfg = w;
      cmd_q.push_back(cmd_t'{1'b1, a, dt, w + 1});
      write_req = 1'b1;
      address = a;
      wdata = dt;
      #1 chk("busy_st_req", busywait, 1);
      tick();
      write_req = 1'b0;
      address = ~a;
      wdata = ~dt;
      for (int i = 0; i <= w; i++) begin
         chk("busy_wr_wait", busywait, 1);
         tick();
      end
      chk("busy_st_done", busywait, 0);
      chk("rf_idx_after_st", rf_inaddress, last_idx);
      chk("rf_data_after_st", rf_in, last_data);
   endtask

   initial begin
      // Reset state, with a request pending that must be ignored.
      read_req = 1'b1;
      address = 8'h99;
      tick();
      chk("rst_busy", busywait, 0);
      tick();
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_addr", mem_address, 8'h00);
      chk("rst_mem_wdata", mem_writedata, 8'h00);
      chk("rst_rf_write", rf_write, 0);
      chk("rst_rf_idx", rf_inaddress, 0);
      chk("rst_rf_in", rf_in, 8'h00);
      chk("rst_timeout", timeout, 0);
      read_req = 1'b0;
      rst = 1'b0;
      tick();
      chk("idle_busy", busywait, 0);

      // Load with 4 busy cycles, then store with 2 busy cycles.
      do_load(8'h10, 3'd5, 8'h2A, 4, 1'b0, 1'b0);
      do_store(8'h20, 8'h7F, 2);

      // Simultaneous requests: read wins. Write noise during the load ignored.
      do_load(8'h31, 3'd2, 8'hC3, 1, 1'b1, 1'b1);
      tick();

      // Back-to-back load and store, zero memory wait.
      do_load(8'h40, 3'd7, 8'h5A, 0, 1'b0, 1'b0);
      do_store(8'h41, 8'hA5, 0);
      tick();

      // Reset in the second RD_WAIT cycle.
      mem_wait_cfg = 1000;
      rdata_cfg = 8'h77;
      cmd_q.push_back(cmd_t'{1'b0, 8'h33, 8'h00, 2});
      read_req = 1'b1;
      address = 8'h33;
      dest_reg = 3'd4;
      tick();
      read_req = 1'b0;
      tick();
      chk("rd2_mem_read", mem_read, 1);
      rst = 1'b1;
      read_req = 1'b1;
      #1 chk("rst_rd_busy", busywait, 0);
      tick();
      chk("rst_rd_mem_read", mem_read, 0);
      chk("rst_rd_rf_write", rf_write, 0);
      chk("rst_rd_busy2", busywait, 0);
      chk("rst_rd_addr", mem_address, 8'h00);
      chk("rst_rd_rf_in", rf_in, 8'h00);
      read_req = 1'b0;
      rst = 1'b0;
      last_idx = 3'd0;
      last_data = 8'h00;
      tick();

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
      // Stuck memory: abort after 8 busy cycles, TIMEOUT sticky until reset.
      mem_wait_cfg = 100000;
      cmd_q.push_back(cmd_t'{1'b0, 8'h44, 8'h00, 8});
      read_req = 1'b1;
      address = 8'h44;
      dest_reg = 3'd3;
      tick();
      read_req = 1'b0;
      repeat (7) tick();
      chk("to_still_waiting", mem_read, 1);
      chk("to_not_yet", timeout, 0);
      tick();
      chk("to_aborted", mem_read, 0);
      chk("to_flag", timeout, 1);
      chk("to_busy", busywait, 0);
      tick();
      do_load(8'h45, 3'd6, 8'h3C, 5, 1'b0, 1'b0);
      chk("to_sticky", timeout, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_idx = 3'd0;
      last_data = 8'h00;
      chk("to_cleared", timeout, 0);
      tick();
`else
      // Stuck memory without a timeout: still waiting after 300 cycles.
      mem_wait_cfg = 100000;
      cmd_q.push_back(cmd_t'{1'b0, 8'h44, 8'h00, 301});
      read_req = 1'b1;
      address = 8'h44;
      dest_reg = 3'd3;
      tick();
      read_req = 1'b0;
      repeat (300) tick();
      chk("nto_mem_read", mem_read, 1);
      chk("nto_busy", busywait, 1);
      chk("nto_timeout", timeout, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_idx = 3'd0;
      last_data = 8'h00;
      chk("nto_reset_exit", mem_read, 0);
      tick();
`endif

      do_store(8'h50, 8'h0F, 1);
      repeat (3) tick();
      chk("cmd_q_drained", cmd_q.size(), 0);
      chk("wb_q_drained", wb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
